sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-port arbiter that shares the single 18-bit-address / 32-bit-data frame SRAM between the camera DMA writer and the image-processing engine. It sits between both requesters and the SRAM controller and issues at most one access per clock. The camera gets priority so pixel words are never dropped. The processing engine gets a guaranteed slot at least every `CAM_BURST_MAX`+1 cycles, plus atomic lock support for read-modify-write.

## Interface
Parameters:
- `ADDR_W`, 18, SRAM word address width
- `DATA_W`, 32, SRAM word width
- `CAM_BURST_MAX`, 16, max consecutive camera grants while processing waits (1..255)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cam_req`  in  1  camera write request; held until accepted
- `cam_addr`  in  ADDR_W  camera write address
- `cam_wdata`  in  DATA_W  camera write data
- `cam_ack`  out  1  combinational grant; write accepted at an edge where `cam_req && cam_ack`
- `proc_req`  in  1  processing request; held until accepted
- `proc_we`  in  1  1 = write, 0 = read
- `proc_lock`  in  1  hold ownership after this access (RMW)
- `proc_addr`  in  ADDR_W  processing address
- `proc_wdata`  in  DATA_W  processing write data
- `proc_ack`  out  1  combinational grant; access accepted at an edge where `proc_req && proc_ack`
- `proc_rdata`  out  DATA_W  read data, registered
- `proc_rvalid`  out  1  one-cycle pulse; `proc_rdata` valid
- `mem_en`  out  1  registered access strobe to SRAM
- `mem_we`  out  1  registered write enable
- `mem_addr`  out  ADDR_W  registered address
- `mem_wdata`  out  DATA_W  registered write data
- `mem_rdata`  in  DATA_W  SRAM read data, valid the cycle after `mem_en` is sampled
- `owner`  out  2  current owner state, for debug/LEDs

## Operation
- Owner FSM, `owner` encoding: IDLE=0, CAM=1, PROC=2, PROC_LOCKED=3. State records the last accepted requester.
- Grant (combinational, at most one ack high):
  - PROC_LOCKED: `proc_ack = proc_req`, `cam_ack = 0`.
  - Otherwise, if `proc_req && run_cnt == CAM_BURST_MAX`: `proc_ack = 1`, `cam_ack = 0`.
  - Otherwise `cam_ack = cam_req`, then `proc_ack = proc_req && !cam_req`.
- `run_cnt` (8-bit):
  - +1 on each cam acceptance while `proc_req` = 1, saturating at `CAM_BURST_MAX`.
  - Cleared on proc acceptance, or on any cycle with `proc_req` = 0.
- On acceptance:
  - `mem_en` = 1; `mem_we` = 1 for cam, `proc_we` for proc.
  - `mem_addr`/`mem_wdata` load from the winner.
  - `owner` becomes CAM, or PROC_LOCKED if `proc_lock` = 1, else PROC.
- No acceptance:
  - `mem_en` = `mem_we` = 0; `mem_addr`/`mem_wdata` hold.
  - `owner` becomes IDLE, except PROC_LOCKED stays PROC_LOCKED while `proc_lock` = 1.
- PROC_LOCKED exits:
  - On a proc acceptance with `proc_lock` = 0 → PROC.
  - When `proc_lock` drops with no request → IDLE.
  - Camera stalls for the whole lock.
- Read return: an accepted proc read sets a 2-stage pipe. `proc_rdata <= mem_rdata` and `proc_rvalid` = 1 exactly 2 edges after acceptance. Back-to-back reads return in order, one per cycle.
- Writes produce no `proc_rvalid`.

## Timing
- Reset (async assert, sync use after release):
  - `mem_en`, `mem_we`, `proc_rvalid` = 0.
  - `mem_addr`, `mem_wdata`, `proc_rdata` = 0.
  - `owner` = IDLE, `run_cnt` = 0, read pipe cleared.
- Reset mid-read: the pending `proc_rvalid` is discarded.
- Acceptance at edge E: `mem_*` valid E→E+1. Read data captured at E+2. `proc_rvalid` high E+2→E+3.
- Throughput: one access per cycle. Simultaneous requests cost no idle cycle.
- Requester rule: if `req` stays high after acceptance, it is treated as a new request with the current addr/data. `ack` is already visible in the acceptance cycle.
- `CAM_BURST_MAX` boundary: with both requesting continuously, the pattern is exactly `CAM_BURST_MAX` cam grants, then 1 proc grant, repeating.

## Test plan
- Cam alone, 4 writes to 0x00010..0x00013, data 0xA0..0xA3 → `mem_en`/`mem_we` high 4 consecutive cycles, matching addr/data, `owner`=1, then IDLE.
- Proc read 0x12345 with SRAM model returning 0xDEADBEEF → `mem_we`=0 at E; `proc_rvalid` pulse at E+2 with `proc_rdata`=0xDEADBEEF.
- Both requesting continuously, `CAM_BURST_MAX`=16 → grant sequence 16 cam, 1 proc, 16 cam…; proc never waits more than 16 cycles.
- Proc locked RMW: read with `proc_lock`=1, then write with `proc_lock`=0, cam requesting throughout → no cam grant between the two, `owner` 3 then 2, cam granted next cycle.
- Assert `rst_n` low one cycle after a proc read is accepted → all outputs 0 immediately; no `proc_rvalid` after release.
- Back-to-back proc reads 0x0, 0x1, 0x2 → three consecutive `proc_rvalid` pulses with data in order, starting 2 cycles after the first acceptance.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for the shared frame SRAM: camera writes have priority, the processing
// engine gets a slot after at most CAM_BURST_MAX camera grants, and can lock the port for RMW.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W        = 18,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned CAM_BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_req,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_wdata,
  output logic              cam_ack,
  input  logic              proc_req,
  input  logic              proc_we,
  input  logic              proc_lock,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic              proc_ack,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              proc_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StCam        = 2'd1,
    StProc       = 2'd2,
    StProcLocked = 2'd3
  } owner_e;

  localparam logic [7:0] BurstMax = 8'(CAM_BURST_MAX);

  owner_e     state_q, state_d;
  logic [7:0] run_cnt_q, run_cnt_d;
  logic       cam_acc, proc_acc;
  logic       rd_p1_q, rd_p2_q;

  // Grant decode: lock beats everything, then the starvation guard, then camera priority.
  always_comb begin
    cam_ack  = 1'b0;
    proc_ack = 1'b0;
    if (state_q == StProcLocked) begin
      proc_ack = proc_req;
    end else if (proc_req && (run_cnt_q == BurstMax)) begin
      proc_ack = 1'b1;
    end else begin
      cam_ack  = cam_req;
      proc_ack = proc_req && !cam_req;
    end
  end

  assign cam_acc  = cam_req && cam_ack;
  assign proc_acc = proc_req && proc_ack;

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (proc_acc || !proc_req) begin
      run_cnt_d = 8'd0;
    end else if (cam_acc && (run_cnt_q < BurstMax)) begin
      run_cnt_d = run_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = StIdle;
    if (proc_acc) begin
      state_d = proc_lock ? StProcLocked : StProc;
    end else if (cam_acc) begin
      state_d = StCam;
    end else if ((state_q == StProcLocked) && proc_lock) begin
      state_d = StProcLocked;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      run_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  assign owner = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= cam_acc || proc_acc;
      mem_we <= cam_acc || (proc_acc && proc_we);
      if (proc_acc) begin
        mem_addr  <= proc_addr;
        mem_wdata <= proc_wdata;
      end else if (cam_acc) begin
        mem_addr  <= cam_addr;
        mem_wdata <= cam_wdata;
      end
    end
  end

  // SRAM returns data one cycle after it samples mem_en, so capture lands two edges after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1_q     <= 1'b0;
      rd_p2_q     <= 1'b0;
      proc_rvalid <= 1'b0;
      proc_rdata  <= '0;
    end else begin
      rd_p1_q     <= proc_acc && !proc_we;
      rd_p2_q     <= rd_p1_q;
      proc_rvalid <= rd_p2_q;
      if (rd_p2_q) begin
        proc_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: stimulus pushes expected SRAM accesses and read returns,
// a negedge monitor pops and compares them whenever mem_en or proc_rvalid is seen.
module tb_sram_port_arbiter;

  localparam int AW = 18;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cam_req, cam_ack, proc_req, proc_we, proc_lock, proc_ack;
  logic [AW-1:0] cam_addr, proc_addr, mem_addr;
  logic [DW-1:0] cam_wdata, proc_wdata, proc_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          proc_rvalid, mem_en, mem_we;
  logic [1:0]    owner;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_t;

  mem_t          exp_mem[$];
  logic [DW-1:0] exp_rd[$];
  int            vectors = 0;
  int            miscompares = 0;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CAM_BURST_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cam_req(cam_req), .cam_addr(cam_addr), .cam_wdata(cam_wdata), .cam_ack(cam_ack),
    .proc_req(proc_req), .proc_we(proc_we), .proc_lock(proc_lock), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_ack(proc_ack), .proc_rdata(proc_rdata),
    .proc_rvalid(proc_rvalid), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  // SRAM model: read data valid the cycle after mem_en is sampled.
  always @(posedge clk) begin
    if (mem_en && !mem_we) begin
      mem_rdata <= (mem_addr == 18'h12345) ? 32'hDEADBEEF : (32'hC000_0000 | 32'(mem_addr));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    mem_t          e;
    logic [DW-1:0] r;
    if (mem_en) begin
      if (exp_mem.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mem_stray: got access to %0h expected none", mem_addr);
      end else begin
        e = exp_mem.pop_front();
        check("mem_access", 64'({mem_we, mem_addr, mem_wdata}), 64'(e));
      end
    end
    if (proc_rvalid) begin
      if (exp_rd.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rvalid_stray: got data %0h expected no pulse", proc_rdata);
      end else begin
        r = exp_rd.pop_front();
        check("rdata", 64'(proc_rdata), 64'(r));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bit pw;
    int cnt;
    rst_n = 1'b0; cam_req = 1'b0; cam_addr = '0; cam_wdata = '0;
    proc_req = 1'b0; proc_we = 1'b0; proc_lock = 1'b0; proc_addr = '0; proc_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", 64'(mem_en), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_rvalid", 64'(proc_rvalid), 64'(0));
    check("rst_rdata", 64'(proc_rdata), 64'(0));
    check("rst_owner", 64'(owner), 64'(0));
    cyc();
    rst_n = 1'b1;

    // Camera alone: four back-to-back writes.
    for (int i = 0; i < 4; i++) begin
      cam_req = 1'b1; cam_addr = 18'(16 + i); cam_wdata = 32'(160 + i);
      @(negedge clk);
      check("cam_ack", 64'(cam_ack), 64'(1));
      check("cam_only_proc_ack", 64'(proc_ack), 64'(0));
      exp_mem.push_back({1'b1, cam_addr, cam_wdata});
      cyc();
    end
    cam_req = 1'b0;
    @(negedge clk);
    check("owner_cam", 64'(owner), 64'(1));
    cyc();
    @(negedge clk);
    check("owner_idle", 64'(owner), 64'(0));
    cyc();

    // Single processing read with exact return latency.
    proc_req = 1'b1; proc_we = 1'b0; proc_addr = 18'h12345; proc_wdata = '0;
    @(negedge clk);
    check("rd_proc_ack", 64'(proc_ack), 64'(1));
    check("rd_cam_ack", 64'(cam_ack), 64'(0));
    exp_mem.push_back({1'b0, 18'h12345, 32'h0});
    exp_rd.push_back(32'hDEADBEEF);
    cyc();
    proc_req = 1'b0;
    @(negedge clk);
    check("rd_mem_we", 64'(mem_we), 64'(0));
    check("rd_owner", 64'(owner), 64'(2));
    check("rd_rvalid_e0", 64'(proc_rvalid), 64'(0));
    cyc();
    @(negedge clk);
    check("rd_rvalid_e1", 64'(proc_rvalid), 64'(0));
    cyc();
    @(negedge clk);
    check("rd_rvalid_e2", 64'(proc_rvalid), 64'(1));
    cyc();
    @(negedge clk);
    check("rd_rvalid_e3", 64'(proc_rvalid), 64'(0));
    cyc();

    // Both requesting continuously: 16 cam, 1 proc, repeating.
    cam_req = 1'b1; cam_addr = 18'h00100; cam_wdata = 32'h00C0FFEE;
    proc_req = 1'b1; proc_we = 1'b1; proc_lock = 1'b0;
    proc_addr = 18'h00200; proc_wdata = 32'h00005A5A;
    for (int j = 0; j < 34; j++) begin
      pw = ((j % 17) == 16);
      @(negedge clk);
      check("burst_cam_ack", 64'(cam_ack), 64'(!pw));
      check("burst_proc_ack", 64'(proc_ack), 64'(pw));
      if (pw) exp_mem.push_back({1'b1, 18'h00200, 32'h00005A5A});
      else    exp_mem.push_back({1'b1, 18'h00100, 32'h00C0FFEE});
      cyc();
    end
    cam_req = 1'b0; proc_req = 1'b0; proc_we = 1'b0;
    @(negedge clk);
    check("burst_owner", 64'(owner), 64'(2));
    cyc();

    // Locked RMW with the camera requesting throughout.
    cam_req = 1'b1; cam_addr = 18'h00500; cam_wdata = 32'h11111111;
    proc_req = 1'b1; proc_we = 1'b0; proc_lock = 1'b1; proc_addr = 18'h00300; proc_wdata = '0;
    for (int j = 0; j < 17; j++) begin
      pw = (j == 16);
      @(negedge clk);
      check("lk_cam_ack", 64'(cam_ack), 64'(!pw));
      check("lk_proc_ack", 64'(proc_ack), 64'(pw));
      if (pw) begin
        exp_mem.push_back({1'b0, 18'h00300, 32'h0});
        exp_rd.push_back(32'hC000_0300);
      end else begin
        exp_mem.push_back({1'b1, 18'h00500, 32'h11111111});
      end
      cyc();
    end
    proc_req = 1'b0;
    @(negedge clk);
    check("lk_owner_held", 64'(owner), 64'(3));
    check("lk_cam_stall", 64'(cam_ack), 64'(0));
    cyc();
    proc_req = 1'b1; proc_we = 1'b1; proc_lock = 1'b0; proc_wdata = 32'h12345678;
    @(negedge clk);
    check("lk_owner_wr", 64'(owner), 64'(3));
    check("lk_wr_proc_ack", 64'(proc_ack), 64'(1));
    check("lk_wr_cam_ack", 64'(cam_ack), 64'(0));
    exp_mem.push_back({1'b1, 18'h00300, 32'h12345678});
    cyc();
    proc_req = 1'b0; proc_we = 1'b0;
    @(negedge clk);
    check("lk_owner_after", 64'(owner), 64'(2));
    check("lk_cam_resume", 64'(cam_ack), 64'(1));
    exp_mem.push_back({1'b1, 18'h00500, 32'h11111111});
    cyc();
    cam_req = 1'b0;
    @(negedge clk);
    check("lk_owner_cam", 64'(owner), 64'(1));
    cyc();

    // Reset one cycle after a read is accepted: pending return is dropped.
    proc_req = 1'b1; proc_we = 1'b0; proc_addr = 18'h00400; proc_wdata = 32'hFFFF0000;
    @(negedge clk);
    check("rst_rd_ack", 64'(proc_ack), 64'(1));
    exp_mem.push_back({1'b0, 18'h00400, 32'hFFFF0000});
    cyc();
    proc_req = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    check("arst_mem_en", 64'(mem_en), 64'(0));
    check("arst_mem_addr", 64'(mem_addr), 64'(0));
    check("arst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("arst_rdata", 64'(proc_rdata), 64'(0));
    check("arst_rvalid", 64'(proc_rvalid), 64'(0));
    check("arst_owner", 64'(owner), 64'(0));
    @(posedge clk);
    cyc();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (proc_rvalid) cnt++;
      cyc();
    end
    check("arst_no_rvalid", 64'(cnt), 64'(0));

    // Back-to-back reads: three in-order returns starting two cycles after the first.
    for (int k = 0; k < 7; k++) begin
      if (k < 3) begin
        proc_req = 1'b1; proc_we = 1'b0; proc_addr = 18'(k); proc_wdata = '0;
      end else begin
        proc_req = 1'b0;
      end
      @(negedge clk);
      check("b2b_rvalid", 64'(proc_rvalid), 64'((k >= 3) && (k <= 5)));
      if (k < 3) begin
        check("b2b_ack", 64'(proc_ack), 64'(1));
        exp_mem.push_back({1'b0, 18'(k), 32'h0});
        exp_rd.push_back(32'hC000_0000 | 32'(k));
      end
      cyc();
    end

    @(negedge clk);
    check("mem_queue_empty", 64'(exp_mem.size()), 64'(0));
    check("rd_queue_empty", 64'(exp_rd.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
